cla_adder_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes. The WIDTH-bit operation is split into BLOCK-bit lookahead slices, one per register stage, so the carry chain crosses one slice per cycle. It is the arithmetic core behind the datapath ALU and supersedes the fixed 32-bit combinational adder. It adds back-pressure, subtract mode and true group generate/propagate outputs.

---
 rtl/cla_pkg.sv | 21 ++
 rtl/cla_block.sv | 44 ++++
 rtl/cla_adder_pipe.sv | 167 ++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared types and elaboration helpers for the cla_adder_pipe slice pipeline
package cla_pkg;

   function automatic bit cla_block_legal(input int blk);
      return blk == 4 || blk == 8 || blk == 16;
   endfunction

   function automatic int cla_stages(input int width, input int blk);
      return width / blk;
   endfunction

   // Fixed-width part of a stage payload; sum_acc, a_rem and b_rem change width from
   // stage to stage, so each stage declares those next to this struct.
   typedef struct packed {
      logic carry;
      logic gg;
      logic pg;
      logic valid;
   } cla_ctl_t;

endpackage

// File: rtl/cla_block.sv
// cla_block: combinational BLOCK-bit carry-lookahead slice with group generate/propagate
module cla_block #(
   parameter int BLOCK = 16
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             ci,
   output logic [BLOCK-1:0] s,
   output logic             co,
   output logic             G,
   output logic             P
);

   logic [BLOCK-1:0] w_g;
   logic [BLOCK-1:0] w_p;
   logic [BLOCK-1:0] w_c;
   logic             w_gr;
   logic             w_pr;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // every carry is the running group generate/propagate of the lower bits applied to ci
   always_comb begin
      logic w_gx;
      logic w_px;
      w_gx = 1'b0;
      w_px = 1'b1;
      w_c  = '0;
      for (int i = 0; i < BLOCK; i++) begin
         w_c[i] = w_gx | (w_px & ci);
         w_gx   = w_g[i] | (w_p[i] & w_gx);
         w_px   = w_p[i] & w_px;
      end
      w_gr = w_gx;
      w_pr = w_px;
   end

   assign s  = w_p ^ w_c;
   assign G  = w_gr;
   assign P  = w_pr;
   assign co = w_gr | (w_pr & ci);

endmodule

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined carry-lookahead add/sub, one BLOCK slice per stage; CLA_FLAGS_EN adds zero/neg/ovf
module cla_adder_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BLOCK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             gg,
   output logic             pg
`ifdef CLA_FLAGS_EN
   ,
   output logic             zero,
   output logic             neg,
   output logic             ovf
`endif
);

   localparam int STAGES = cla_stages(WIDTH, BLOCK);
   localparam int LAST   = STAGES - 1;

   if (!cla_block_legal(BLOCK) || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
      $error("cla_adder_pipe: WIDTH must be a multiple of BLOCK and BLOCK one of 4, 8, 16");
   end

   logic [WIDTH-1:0]  w_b_eff;
   logic              w_ci;
   logic [STAGES:0]   w_load;
   logic [STAGES-1:0] w_valid;

   assign w_b_eff = sub ? ~b : b;
   assign w_ci    = sub | c_in;

   // a stage may load when it is empty or its content moves on this cycle
   always_comb begin
      w_load[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--)
         w_load[i] = !w_valid[i] | w_load[i+1];
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO  = k * BLOCK;
      localparam int SRC = WIDTH - LO;

      logic [SRC-1:0]      w_src_a;
      logic [SRC-1:0]      w_src_b;
      logic                w_src_valid;
      logic                w_src_ci;
      logic                w_src_gg;
      logic                w_src_pg;
      logic [BLOCK-1:0]    w_s;
      logic                w_co;
      logic                w_g;
      logic                w_p;
      logic [LO+BLOCK-1:0] w_sum;
      logic [LO+BLOCK-1:0] r_sum;
      cla_ctl_t            r_ctl;

      if (k == 0) begin : g_src
         assign w_src_a     = a;
         assign w_src_b     = w_b_eff;
         assign w_src_valid = in_valid;
         assign w_src_ci    = w_ci;
         assign w_src_gg    = 1'b0;
         assign w_src_pg    = 1'b1;
         assign w_sum       = w_s;
      end else begin : g_src
         assign w_src_a     = g_stage[k-1].g_rem.r_a;
         assign w_src_b     = g_stage[k-1].g_rem.r_b;
         assign w_src_valid = g_stage[k-1].r_ctl.valid;
         assign w_src_ci    = g_stage[k-1].r_ctl.carry;
         assign w_src_gg    = g_stage[k-1].r_ctl.gg;
         assign w_src_pg    = g_stage[k-1].r_ctl.pg;
         assign w_sum       = {w_s, g_stage[k-1].r_sum};
      end

      cla_block #(.BLOCK(BLOCK)) u_blk (
         .a  (w_src_a[BLOCK-1:0]),
         .b  (w_src_b[BLOCK-1:0]),
         .ci (w_src_ci),
         .s  (w_s),
         .co (w_co),
         .G  (w_g),
         .P  (w_p)
      );

      assign w_valid[k] = r_ctl.valid;

      // register this slice; payload moves only with a real beat so idle stages hold their contents
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_ctl <= '0;
            r_sum <= '0;
         end else if (w_load[k]) begin
            r_ctl.valid <= w_src_valid;
            if (w_src_valid) begin
               r_ctl.carry <= w_co;
               r_ctl.gg    <= w_g | (w_p & w_src_gg);
               r_ctl.pg    <= w_p & w_src_pg;
               r_sum       <= w_sum;
            end
         end
      end

      if (k < LAST) begin : g_rem
         logic [SRC-BLOCK-1:0] r_a;
         logic [SRC-BLOCK-1:0] r_b;

         // hand the not-yet-added operand slices to the next stage
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_load[k] && w_src_valid) begin
               r_a <= w_src_a[SRC-1:BLOCK];
               r_b <= w_src_b[SRC-1:BLOCK];
            end
         end
      end
   end

`ifdef CLA_FLAGS_EN
   logic w_ovf;
   logic r_zero;
   logic r_neg;
   logic r_ovf;

   assign w_ovf = (g_stage[LAST].w_src_a[BLOCK-1] == g_stage[LAST].w_src_b[BLOCK-1]) &
                  (g_stage[LAST].w_sum[WIDTH-1] != g_stage[LAST].w_src_a[BLOCK-1]);

   // flags ride with the final sum so they stay aligned under back-pressure
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_zero <= 1'b0;
         r_neg  <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_load[LAST] && g_stage[LAST].w_src_valid) begin
         r_zero <= ~|g_stage[LAST].w_sum;
         r_neg  <= g_stage[LAST].w_sum[WIDTH-1];
         r_ovf  <= w_ovf;
      end
   end

   assign zero = r_zero;
   assign neg  = r_neg;
   assign ovf  = r_ovf;
`endif

   assign in_ready  = w_load[0] & rst_n;
   assign out_valid = w_valid[LAST] & rst_n;
   assign sum       = g_stage[LAST].r_sum;
   assign c_out     = g_stage[LAST].r_ctl.carry;
   assign gg        = g_stage[LAST].r_ctl.gg;
   assign pg        = g_stage[LAST].r_ctl.pg;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: directed checks on a 32/16 instance plus a random 24/8 instance against a model
module tb_cla_adder_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid0 = 1'b0, sub0 = 1'b0, cin0 = 1'b0, out_ready0 = 1'b1;
   logic        in_ready0, out_valid0, co0, gg0, pg0;
   logic [31:0] a0 = '0, b0 = '0, sum0;
   logic        in_valid1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0, out_ready1 = 1'b1;
   logic        in_ready1, out_valid1, co1, gg1, pg1;
   logic [23:0] a1 = '0, b1 = '0, sum1;
`ifdef CLA_FLAGS_EN
   logic        zero0, neg0, ovf0, zero1, neg1, ovf1;
`endif

   cla_adder_pipe #(.WIDTH(32), .BLOCK(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
      .a(a0), .b(b0), .sub(sub0), .c_in(cin0), .out_valid(out_valid0),
      .out_ready(out_ready0), .sum(sum0), .c_out(co0), .gg(gg0), .pg(pg0)
`ifdef CLA_FLAGS_EN
      , .zero(zero0), .neg(neg0), .ovf(ovf0)
`endif
   );

   cla_adder_pipe #(.WIDTH(24), .BLOCK(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .sub(sub1), .c_in(cin1), .out_valid(out_valid1),
      .out_ready(out_ready1), .sum(sum1), .c_out(co1), .gg(gg1), .pg(pg1)
`ifdef CLA_FLAGS_EN
      , .zero(zero1), .neg(neg1), .ovf(ovf1)
`endif
   );

   typedef struct packed {
      logic [31:0] sum;
      logic co, gg, pg, zero, neg, ovf;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_tests = 0;
   int   n_fail = 0;
   logic rnd_on = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // f = {c_out, gg, pg, zero, neg, ovf}
   function automatic exp_t mk(input logic [31:0] s, input logic [5:0] f);
      return {s, f};
   endfunction

   function automatic exp_t model24(input logic [23:0] xa, xb, input logic xs, xc);
      logic [23:0] be;
      logic [24:0] r;
      logic [24:0] g;
      be = xs ? ~xb : xb;
      r  = {1'b0, xa} + {1'b0, be} + {24'd0, xs | xc};
      g  = {1'b0, xa} + {1'b0, be};
      return mk({8'h00, r[23:0]}, {r[24], g[24], &(xa ^ be), r[23:0] == 24'd0, r[23],
                                   (xa[23] == be[23]) && (r[23] != xa[23])});
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (out_valid0 && out_ready0) begin
         if (q0.size() == 0) check("spurious0", out_valid0, 0);
         else begin
            e = q0.pop_front();
            check("sum0", sum0, e.sum);
            check("cout0", co0, e.co);
            check("gg0", gg0, e.gg);
            check("pg0", pg0, e.pg);
`ifdef CLA_FLAGS_EN
            check("flags0", {zero0, neg0, ovf0}, {e.zero, e.neg, e.ovf});
`endif
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (out_valid1 && out_ready1) begin
         if (q1.size() == 0) check("spurious1", out_valid1, 0);
         else begin
            e = q1.pop_front();
            check("sum1", {8'h00, sum1}, e.sum);
            check("cout1", co1, e.co);
            check("gg1", gg1, e.gg);
            check("pg1", pg1, e.pg);
`ifdef CLA_FLAGS_EN
            check("flags1", {zero1, neg1, ovf1}, {e.zero, e.neg, e.ovf});
`endif
         end
      end
   end

   task automatic send0(input logic [31:0] xa, xb, input logic xs, xc);
      int n;
      n = 0;
      a0 = xa; b0 = xb; sub0 = xs; cin0 = xc; in_valid0 = 1'b1;
      @(negedge clk);
      while (!in_ready0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept0", in_ready0, 1);
      @(posedge clk); #1;
      in_valid0 = 1'b0;
   endtask

   task automatic send1(input logic [23:0] xa, xb, input logic xs, xc);
      int n;
      n = 0;
      a1 = xa; b1 = xb; sub1 = xs; cin1 = xc; in_valid1 = 1'b1;
      @(negedge clk);
      while (!in_ready1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept1", in_ready1, 1);
      @(posedge clk); #1;
      in_valid1 = 1'b0;
   endtask

   task automatic vec0(input logic [31:0] xa, xb, input logic xs, xc,
                       input logic [31:0] s, input logic [5:0] f);
      q0.push_back(mk(s, f));
      send0(xa, xb, xs, xc);
      check("latency_early", out_valid0, 0);
      @(posedge clk); #1;
      check("latency_due", out_valid0, 1);
      @(posedge clk); #1;
   endtask

   task automatic drain(input int which);
      int n;
      n = 0;
      while ((which == 0 ? q0.size() : q1.size()) != 0 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check(which == 0 ? "drain0" : "drain1", which == 0 ? q0.size() : q1.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready0, 0);
      check("rst_out_valid", out_valid0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", in_ready0, 1);
      check("post_rst_outs", {out_valid0, sum0, co0, gg0, pg0}, 0);
      @(posedge clk); #1;

      vec0(32'h0000FFFF, 32'h00000001, 0, 0, 32'h00010000, 6'b000000);
      vec0(32'h00000005, 32'h00000007, 1, 0, 32'hFFFFFFFE, 6'b000010);
      vec0(32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 6'b000011);
      vec0(32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 6'b110100);
      vec0(32'hFFFF0000, 32'h0000FFFF, 0, 1, 32'h00000000, 6'b101100);
      vec0(32'h12345678, 32'h12345678, 1, 0, 32'h00000000, 6'b101100);
      vec0(32'h0000000A, 32'h00000003, 1, 1, 32'h00000007, 6'b110000);
      vec0(32'h0000FFFF, 32'h00000000, 0, 1, 32'h00010000, 6'b000000);
      vec0(32'h80000000, 32'h00000001, 1, 0, 32'h7FFFFFFF, 6'b110001);

      q0.push_back(mk(32'h00000002, 6'b000000));
      q0.push_back(mk(32'h00000030, 6'b000000));
      q0.push_back(mk(32'h000001FF, 6'b000000));
      q0.push_back(mk(32'h00000001, 6'b110000));
      fork
         begin
            send0(32'h1, 32'h1, 0, 0);
            send0(32'h10, 32'h20, 0, 0);
            send0(32'h100, 32'hFF, 0, 0);
            send0(32'hFFFFFFFF, 32'h2, 0, 0);
         end
         begin
            @(posedge clk); #1;
            out_ready0 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("bp_in_ready", in_ready0, 0);
            check("bp_out_valid", out_valid0, 1);
            repeat (2) @(negedge clk);
            check("bp_hold_sum", sum0, 32'h2);
            check("bp_hold_valid", out_valid0, 1);
            @(posedge clk); #1;
            out_ready0 = 1'b1;
         end
      join
      drain(0);

      out_ready0 = 1'b0;
      send0(32'h11111111, 32'h22222222, 0, 0);
      send0(32'h33333333, 32'h44444444, 1, 0);
      check("rs_in_flight", out_valid0, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rs_out_valid_low", out_valid0, 0);
      check("rs_in_ready_low", in_ready0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready0 = 1'b1;
      @(negedge clk);
      check("rs_in_ready_back", in_ready0, 1);
      check("rs_outs_zero", {sum0, co0, gg0, pg0}, 0);
      repeat (4) begin
         @(negedge clk);
         check("rs_no_valid", out_valid0, 0);
      end
      @(posedge clk); #1;
      vec0(32'hABCD0000, 32'h00001234, 0, 0, 32'hABCD1234, 6'b000010);

      rnd_on = 1'b1;
      fork
         while (rnd_on) begin
            @(posedge clk); #1;
            out_ready1 = 1'($urandom_range(0, 1));
         end
         begin
            for (int i = 0; i < 40; i++) begin
               logic [23:0] ra, rb;
               logic rs, rc;
               ra = 24'($urandom);
               rb = (i % 7 == 3) ? ~ra : 24'($urandom);
               rs = 1'($urandom_range(0, 1));
               rc = 1'($urandom_range(0, 1));
               q1.push_back(model24(ra, rb, rs, rc));
               send1(ra, rb, rs, rc);
               if (i % 5 == 4) begin
                  @(posedge clk); #1;
               end
            end
            rnd_on = 1'b0;
         end
      join
      out_ready1 = 1'b1;
      drain(1);
      drain(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
